// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for the ID/EX stage: decoded instruction in, registered
// instruction plus hazard controls out. master = decode side, slave = ID/EX stage.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [4:0]        ifid_rs;
  logic [4:0]        ifid_rt;
  logic [4:0]        ifid_rd;
  logic [1:0]        id_wb;
  logic [1:0]        id_m;
  logic [3:0]        id_ex;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc4;
  logic              flush;

  logic [1:0]        idex_wb;
  logic [1:0]        idex_m;
  logic [3:0]        idex_ex;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [DATA_W-1:0] idex_imm;
  logic [DATA_W-1:0] idex_pc4;
  logic [4:0]        idex_rs;
  logic [4:0]        idex_rt;
  logic [4:0]        idex_rd;
  logic              pc_write;
  logic              ifid_write;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output ifid_rs, ifid_rt, ifid_rd, id_wb, id_m, id_ex,
           id_rs_data, id_rt_data, id_imm, id_pc4, flush,
    input  idex_wb, idex_m, idex_ex, idex_rs_data, idex_rt_data, idex_imm, idex_pc4,
           idex_rs, idex_rt, idex_rd, pc_write, ifid_write, stall, stall_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_rd, id_wb, id_m, id_ex,
           id_rs_data, id_rt_data, id_imm, id_pc4, flush,
    output idex_wb, idex_m, idex_ex, idex_rs_data, idex_rt_data, idex_imm, idex_pc4,
           idex_rs, idex_rt, idex_rd, pc_write, ifid_write, stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional saturating stall counter is built only when IDEX_STALL_CNT_EN is defined.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic hazard;
  logic bubble;

  // Conservative: both source fields compared, rt==0 still counts as a match.
  assign hazard         = bus.idex_m[1] &&
                          ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
  assign bus.stall      = hazard && !bus.flush;
  assign bus.pc_write   = !bus.stall;
  assign bus.ifid_write = !bus.stall;
  assign bubble         = bus.flush || bus.stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.idex_wb      <= 2'b00;
      bus.idex_m       <= 2'b00;
      bus.idex_ex      <= 4'b0000;
      bus.idex_rs_data <= {DATA_W{1'b0}};
      bus.idex_rt_data <= {DATA_W{1'b0}};
      bus.idex_imm     <= {DATA_W{1'b0}};
      bus.idex_pc4     <= {DATA_W{1'b0}};
      bus.idex_rs      <= 5'd0;
      bus.idex_rt      <= 5'd0;
      bus.idex_rd      <= 5'd0;
    end else begin
      // A bubble only zeroes control; datapath fields still load so they stay deterministic.
      if (bubble) begin
        bus.idex_wb <= 2'b00;
        bus.idex_m  <= 2'b00;
        bus.idex_ex <= 4'b0000;
      end else begin
        bus.idex_wb <= bus.id_wb;
        bus.idex_m  <= bus.id_m;
        bus.idex_ex <= bus.id_ex;
      end
      bus.idex_rs_data <= bus.id_rs_data;
      bus.idex_rt_data <= bus.id_rt_data;
      bus.idex_imm     <= bus.id_imm;
      bus.idex_pc4     <= bus.id_pc4;
      bus.idex_rs      <= bus.ifid_rs;
      bus.idex_rt      <= bus.ifid_rt;
      bus.idex_rd      <= bus.ifid_rd;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (bus.stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, load-use stall,
// flush priority, rt==0 hazard, stall counter saturation and reset during a stall.
module tb_id_ex_stage;

`ifdef IDEX_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_ex_stage_if #(.DATA_W(32), .CNT_W(2)) bus ();

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] d);
    bus.id_wb      = wb;
    bus.id_m       = m;
    bus.id_ex      = ex;
    bus.ifid_rs    = rs;
    bus.ifid_rt    = rt;
    bus.ifid_rd    = rd;
    bus.id_rs_data = d;
    bus.id_rt_data = d + 32'd1;
    bus.id_imm     = d + 32'd2;
    bus.id_pc4     = d + 32'd3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    drive(2'b11, 2'b10, 4'b1111, 5'd9, 5'd9, 5'd9, 32'hDEAD_0000);
    tick();
    tick();
    total++; if (bus.idex_wb !== 2'b00) begin bad++; $display("FAIL rst_wb got=%b exp=00", bus.idex_wb); end
    total++; if (bus.idex_m !== 2'b00) begin bad++; $display("FAIL rst_m got=%b exp=00", bus.idex_m); end
    total++; if (bus.idex_ex !== 4'b0000) begin bad++; $display("FAIL rst_ex got=%b exp=0000", bus.idex_ex); end
    total++; if (bus.idex_rs_data !== 32'd0 || bus.idex_pc4 !== 32'd0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0", bus.idex_rs_data, bus.idex_pc4); end
    total++; if ({bus.idex_rs, bus.idex_rt, bus.idex_rd} !== 15'd0) begin bad++; $display("FAIL rst_fields got=%h exp=0", {bus.idex_rs, bus.idex_rt, bus.idex_rd}); end
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin bad++; $display("FAIL rst_ctl got=%b%b%b exp=011", bus.stall, bus.pc_write, bus.ifid_write); end
    total++; if (bus.stall_count !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_count); end
  endtask

  task automatic test_add();
    rst = 1'b0;
    drive(2'b10, 2'b00, 4'b1010, 5'd1, 5'd2, 5'd3, 32'h0000_0011);
    #1;
    total++; if (bus.idex_wb !== 2'b00) begin bad++; $display("FAIL add_early got=%b exp=00", bus.idex_wb); end
    tick();
    total++; if (bus.idex_wb !== 2'b10 || bus.idex_m !== 2'b00 || bus.idex_ex !== 4'b1010) begin bad++; $display("FAIL add_ctl got=%b/%b/%b exp=10/00/1010", bus.idex_wb, bus.idex_m, bus.idex_ex); end
    total++; if (bus.idex_rs !== 5'd1 || bus.idex_rt !== 5'd2 || bus.idex_rd !== 5'd3) begin bad++; $display("FAIL add_fields got=%0d/%0d/%0d exp=1/2/3", bus.idex_rs, bus.idex_rt, bus.idex_rd); end
    total++; if (bus.idex_rs_data !== 32'h11 || bus.idex_rt_data !== 32'h12 || bus.idex_imm !== 32'h13 || bus.idex_pc4 !== 32'h14) begin bad++; $display("FAIL add_data got=%h/%h/%h/%h exp=11/12/13/14", bus.idex_rs_data, bus.idex_rt_data, bus.idex_imm, bus.idex_pc4); end
  endtask

  task automatic test_load_use();
    drive(2'b11, 2'b10, 4'b0100, 5'd4, 5'd5, 5'd0, 32'h0000_0040);
    tick();
    total++; if (bus.idex_m !== 2'b10 || bus.idex_rt !== 5'd5) begin bad++; $display("FAIL lw_in_ex got=%b/%0d exp=10/5", bus.idex_m, bus.idex_rt); end
    drive(2'b10, 2'b00, 4'b1010, 5'd5, 5'd6, 5'd7, 32'h0000_0055);
    #1;
    total++; if (bus.stall !== 1'b1 || bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b%b%b exp=100", bus.stall, bus.pc_write, bus.ifid_write); end
    tick();
    total++; if (bus.idex_wb !== 2'b00 || bus.idex_m !== 2'b00 || bus.idex_ex !== 4'b0000) begin bad++; $display("FAIL lu_bubble got=%b/%b/%b exp=0", bus.idex_wb, bus.idex_m, bus.idex_ex); end
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1) begin bad++; $display("FAIL lu_release got=%b%b exp=01", bus.stall, bus.pc_write); end
    total++; if (bus.stall_count !== (CNT_EN ? 2'd1 : 2'd0)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.stall_count, CNT_EN ? 1 : 0); end
    tick();
    total++; if (bus.idex_wb !== 2'b10 || bus.idex_ex !== 4'b1010 || bus.idex_rs !== 5'd5 || bus.idex_rd !== 5'd7 || bus.idex_rs_data !== 32'h55) begin bad++; $display("FAIL lu_held got=%b/%b/%0d/%0d/%h exp=10/1010/5/7/55", bus.idex_wb, bus.idex_ex, bus.idex_rs, bus.idex_rd, bus.idex_rs_data); end
  endtask

  task automatic test_no_hazard();
    drive(2'b11, 2'b10, 4'b0100, 5'd4, 5'd5, 5'd0, 32'h0000_0040);
    tick();
    drive(2'b10, 2'b00, 4'b1010, 5'd6, 5'd7, 5'd8, 32'h0000_0066);
    #1;
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin bad++; $display("FAIL nh_ctl got=%b%b%b exp=011", bus.stall, bus.pc_write, bus.ifid_write); end
    tick();
    total++; if (bus.idex_wb !== 2'b10 || bus.idex_ex !== 4'b1010 || bus.idex_rt !== 5'd7 || bus.idex_rd !== 5'd8) begin bad++; $display("FAIL nh_adv got=%b/%b/%0d/%0d exp=10/1010/7/8", bus.idex_wb, bus.idex_ex, bus.idex_rt, bus.idex_rd); end
  endtask

  task automatic test_flush();
    drive(2'b11, 2'b10, 4'b0100, 5'd4, 5'd5, 5'd0, 32'h0000_0040);
    tick();
    drive(2'b10, 2'b01, 4'b1010, 5'd9, 5'd5, 5'd1, 32'h0000_0077);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rt_match got=%b exp=1", bus.stall); end
    bus.flush = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin bad++; $display("FAIL fl_ctl got=%b%b%b exp=011", bus.stall, bus.pc_write, bus.ifid_write); end
    tick();
    bus.flush = 1'b0;
    total++; if (bus.idex_wb !== 2'b00 || bus.idex_m !== 2'b00 || bus.idex_ex !== 4'b0000 || bus.idex_rd !== 5'd1) begin bad++; $display("FAIL fl_bubble got=%b/%b/%b/%0d exp=0/0/0/1", bus.idex_wb, bus.idex_m, bus.idex_ex, bus.idex_rd); end
    total++; if (bus.stall_count !== (CNT_EN ? 2'd1 : 2'd0)) begin bad++; $display("FAIL fl_cnt got=%0d exp=%0d", bus.stall_count, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_zero_rt();
    drive(2'b11, 2'b10, 4'b0100, 5'd3, 5'd0, 5'd0, 32'h0000_0030);
    tick();
    drive(2'b10, 2'b00, 4'b1010, 5'd0, 5'd9, 5'd2, 32'h0000_0088);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL zero_rt got=%b exp=1", bus.stall); end
    tick();
    total++; if (bus.idex_ex !== 4'b0000 || bus.idex_wb !== 2'b00) begin bad++; $display("FAIL zero_bubble got=%b/%b exp=0", bus.idex_ex, bus.idex_wb); end
    total++; if (bus.stall_count !== (CNT_EN ? 2'd2 : 2'd0)) begin bad++; $display("FAIL zero_cnt got=%0d exp=%0d", bus.stall_count, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_stall_count();
    drive(2'b11, 2'b10, 4'b0100, 5'd4, 5'd5, 5'd0, 32'h0000_0040);
    tick();
    drive(2'b10, 2'b00, 4'b1010, 5'd5, 5'd6, 5'd7, 32'h0000_0099);
    tick();
    total++; if (bus.stall_count !== (CNT_EN ? 2'd3 : 2'd0)) begin bad++; $display("FAIL cnt_3 got=%0d exp=%0d", bus.stall_count, CNT_EN ? 3 : 0); end
    drive(2'b11, 2'b10, 4'b0100, 5'd4, 5'd5, 5'd0, 32'h0000_0040);
    tick();
    drive(2'b10, 2'b00, 4'b1010, 5'd5, 5'd6, 5'd7, 32'h0000_0099);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL cnt_stall4 got=%b exp=1", bus.stall); end
    tick();
    total++; if (bus.stall_count !== (CNT_EN ? 2'd3 : 2'd0)) begin bad++; $display("FAIL cnt_sat got=%0d exp=%0d", bus.stall_count, CNT_EN ? 3 : 0); end
  endtask

  task automatic test_rst_mid_stall();
    drive(2'b11, 2'b10, 4'b0100, 5'd4, 5'd5, 5'd0, 32'h0000_0040);
    tick();
    drive(2'b10, 2'b00, 4'b1010, 5'd5, 5'd6, 5'd7, 32'h0000_00AA);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rms_pre got=%b exp=1", bus.stall); end
    rst = 1'b1;
    tick();
    total++; if (bus.idex_wb !== 2'b00 || bus.idex_m !== 2'b00 || bus.idex_ex !== 4'b0000 || bus.idex_rs_data !== 32'd0 || bus.idex_rd !== 5'd0 || bus.idex_rs !== 5'd0) begin bad++; $display("FAIL rms_regs got=%b/%b/%b/%h/%0d/%0d exp=0", bus.idex_wb, bus.idex_m, bus.idex_ex, bus.idex_rs_data, bus.idex_rd, bus.idex_rs); end
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1 || bus.stall_count !== 2'd0) begin bad++; $display("FAIL rms_ctl got=%b/%b/%0d exp=0/1/0", bus.stall, bus.pc_write, bus.stall_count); end
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_zero_rt();
    test_stall_count();
    test_rst_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
